// File: rtl/public_key_gen_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : public_key_gen_seq_if
// Purpose  : Request/response bundle for the sequential public-key generator.
//            Request side : in_valid, in_ready, mode, secret_key
//            Response side: out_valid, out_ready, public_key, out_err
//            master = requester/consumer, slave = generator.
// Revision : 1.0 - initial release
// ============================================================================
interface public_key_gen_seq_if #(
  parameter int W = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] secret_key;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] public_key;
  logic [1:0]   out_err;

  modport master (
    output in_valid, mode, secret_key, out_ready,
    input  in_ready, out_valid, public_key, out_err
  );

  modport slave (
    input  in_valid, mode, secret_key, out_ready,
    output in_ready, out_valid, public_key, out_err
  );
endinterface
`default_nettype wire

// File: rtl/public_key_gen_seq.sv
`default_nettype none
// ============================================================================
// Module   : public_key_gen_seq
// Purpose  : Sequential public-key generator, Pk = (Sk + Q) mod P, reduced by
//            one conditional subtraction of P per cycle. One request in
//            flight; errors are returned as responses with public_key = 0.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            bus        - public_key_gen_seq_if.slave (request/response)
//            busy       - high while in REDUCE or DONE
//            err_count  - saturating count of rejected requests
// Options  : PK_ERR_CNT_EN - when defined, builds the 8-bit error counter;
//            otherwise err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module public_key_gen_seq #(
  parameter int          W        = 8,
  parameter int unsigned P        = 227,
  parameter int unsigned Q        = 225,
  parameter logic [1:0]  MODE_GEN = 2'b01
) (
  input  wire                       clk,
  input  wire                       rst_n,
  public_key_gen_seq_if.slave       bus,
  output logic                      busy,
  output logic [7:0]                err_count
);

  // Constants widened to W+1 bits so Sk + Q never overflows.
  localparam logic [W:0] c_p = (W+1)'(P);
  localparam logic [W:0] c_q = (W+1)'(Q);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       r_state;
  logic [W:0]   r_acc;
  logic         r_out_valid;
  logic [W-1:0] r_public_key;
  logic [1:0]   r_out_err;

  logic         w_accept;
  logic         w_mode_bad;
  logic         w_key_bad;
  logic [W:0]   w_sum;

  assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
  assign w_mode_bad = (bus.mode != MODE_GEN);
  assign w_key_bad  = (bus.secret_key == '0) || ({1'b0, bus.secret_key} >= c_p);
  assign w_sum      = {1'b0, bus.secret_key} + c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_public_key <= '0;
      r_out_err    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_mode_bad) begin
              // Mode error wins over key error.
              r_out_err    <= 2'b10;
              r_public_key <= '0;
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else if (w_key_bad) begin
              r_out_err    <= 2'b01;
              r_public_key <= '0;
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_acc   <= w_sum;
              r_state <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          // acc >= P subtracts, so a sum equal to P reduces to 0.
          if (r_acc >= c_p) begin
            r_acc <= r_acc - c_p;
          end else begin
            r_public_key <= r_acc[W-1:0];
            r_out_err    <= 2'b00;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
            r_public_key <= '0;
            r_out_err    <= 2'b00;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = r_out_valid;
  assign bus.public_key = r_public_key;
  assign bus.out_err    = r_out_err;
  assign busy           = (r_state != S_IDLE);

`ifdef PK_ERR_CNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'h00;
    end else if (w_accept && (w_mode_bad || w_key_bad) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
  assign err_count       = 8'h00;
`endif

endmodule
`default_nettype wire
